// File: rtl/adder16_0_err_eval.sv
// Error-evaluation stage for one BMF partition of adder16: sweeps every input
// vector into externally driven exact/approximate netlists and accumulates error metrics.
module adder16_0_err_eval #(
  parameter int NI  = 6,
  parameter int NO  = 4,
  parameter int LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [NI-1:0]          vec_out,
  output logic                   vec_valid,
  input  logic [NO-1:0]          exact_in,
  input  logic [NO-1:0]          approx_in,
  output logic                   busy,
  output logic                   done,
  output logic [NI:0]            err_count,
  output logic [NI+2:0]          ham_sum,
  output logic [NO*(NI+1)-1:0]   bit_err,
  output logic [NI+NO-1:0]       abs_err_sum,
  output logic [NO-1:0]          max_abs_err
);

  localparam logic [NI-1:0] LAST_VEC = '1;
  localparam int            PW       = $clog2(NO + 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t        state;
  logic [2:0]    drain_cnt;
  logic          sample_vld;
  logic          clear;
  logic [NO-1:0] diff;
  logic [NO-1:0] ae;
  logic [PW-1:0] pop;

  // A new sweep may only be launched from IDLE or DONE; start while busy is dropped.
  assign clear = start && (state == IDLE || state == DONE);

  // Delayed copy of vec_valid marks the cycle in which the partitions' answer arrives.
  generate
    if (LAT == 0) begin : g_no_delay
      assign sample_vld = vec_valid;
    end else begin : g_delay
      logic [LAT-1:0] vld_line;
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_line <= '0;
        end else begin
          vld_line[0] <= vec_valid;
          for (int i = 1; i < LAT; i++) vld_line[i] <= vld_line[i-1];
        end
      end
      assign sample_vld = vld_line[LAT-1];
    end
  endgenerate

  // NOTE: every variable in an always_comb gets a default before any branch, so no latch is inferred.
  always_comb begin
    diff = approx_in ^ exact_in;
    pop  = '0;
    for (int b = 0; b < NO; b++) pop = pop + PW'(diff[b]);
    ae = (approx_in >= exact_in) ? (approx_in - exact_in) : (exact_in - approx_in);
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec_out   <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SWEEP;
            vec_out   <= '0;
            vec_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SWEEP: begin
          if (vec_out == LAST_VEC) begin
            vec_valid <= 1'b0;
            if (LAT > 0) begin
              state     <= DRAIN;
              drain_cnt <= 3'(LAT - 1);
            end else begin
              state <= DONE;
              busy  <= 1'b0;
            end
          end else begin
            vec_out <= vec_out + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        DONE: begin
          // done is raised one cycle after entry so the final sample has already landed.
          if (start) begin
            state     <= SWEEP;
            vec_out   <= '0;
            vec_valid <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Widths cover a full sweep of worst-case errors, so the sums never wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_count   <= '0;
      ham_sum     <= '0;
      bit_err     <= '0;
      abs_err_sum <= '0;
      max_abs_err <= '0;
    end else if (sample_vld) begin
      err_count   <= err_count + (NI+1)'(diff != '0);
      ham_sum     <= ham_sum + (NI+3)'(pop);
      abs_err_sum <= abs_err_sum + (NI+NO)'(ae);
      if (ae > max_abs_err) max_abs_err <= ae;
      for (int b = 0; b < NO; b++)
        bit_err[b*(NI+1) +: NI+1] <= bit_err[b*(NI+1) +: NI+1] + (NI+1)'(diff[b]);
    end
  end

endmodule

// File: tb/tb_adder16_0_err_eval.sv
// Directed bench for adder16_0_err_eval: three builds (LAT 0/1/3) share start/rst and
// are fed by partition models whose latency matches each build.
module tb_adder16_0_err_eval;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   mode;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // Partition model: a small gate-level slice of the adder (bit 2 high on 16 of 64 vectors).
  function automatic logic [3:0] exact_of(int m, logic [5:0] v);
    if (m == 3) return 4'h0;
    return {v[5] ^ v[4], v[3] & v[2], v[1] ^ v[0], v[1] & v[0]};
  endfunction

  function automatic logic [3:0] approx_of(int m, logic [5:0] v);
    logic [3:0] e;
    e = exact_of(m, v);
    case (m)
      1:       return e ^ 4'b0001;
      2:       return e & 4'b1011;
      3:       return 4'hF;
      default: return e;
    endcase
  endfunction

  logic [5:0]  vec_0, vec_1, vec_3;
  logic        vv_0, vv_1, vv_3;
  logic [3:0]  ex_0, ex_1, ex_3, ap_0, ap_1, ap_3;
  logic        busy_0, busy_1, busy_3, done_0, done_1, done_3;
  logic [6:0]  ec_0, ec_1, ec_3;
  logic [8:0]  hs_0, hs_1, hs_3;
  logic [27:0] be_0, be_1, be_3;
  logic [9:0]  as_0, as_1, as_3;
  logic [3:0]  mx_0, mx_1, mx_3;
  logic [5:0]  vq1, vq3a, vq3b, vq3c;

  always @(posedge clk) begin
    vq1  <= vec_1;
    vq3a <= vec_3;
    vq3b <= vq3a;
    vq3c <= vq3b;
  end

  assign ex_0 = exact_of(mode, vec_0);
  assign ap_0 = approx_of(mode, vec_0);
  assign ex_1 = exact_of(mode, vq1);
  assign ap_1 = approx_of(mode, vq1);
  assign ex_3 = exact_of(mode, vq3c);
  assign ap_3 = approx_of(mode, vq3c);

  adder16_0_err_eval #(.NI(6), .NO(4), .LAT(0)) dut_0 (
    .clk(clk), .rst(rst), .start(start), .vec_out(vec_0), .vec_valid(vv_0),
    .exact_in(ex_0), .approx_in(ap_0), .busy(busy_0), .done(done_0),
    .err_count(ec_0), .ham_sum(hs_0), .bit_err(be_0), .abs_err_sum(as_0), .max_abs_err(mx_0));

  adder16_0_err_eval #(.NI(6), .NO(4), .LAT(1)) dut_1 (
    .clk(clk), .rst(rst), .start(start), .vec_out(vec_1), .vec_valid(vv_1),
    .exact_in(ex_1), .approx_in(ap_1), .busy(busy_1), .done(done_1),
    .err_count(ec_1), .ham_sum(hs_1), .bit_err(be_1), .abs_err_sum(as_1), .max_abs_err(mx_1));

  adder16_0_err_eval #(.NI(6), .NO(4), .LAT(3)) dut_3 (
    .clk(clk), .rst(rst), .start(start), .vec_out(vec_3), .vec_valid(vv_3),
    .exact_in(ex_3), .approx_in(ap_3), .busy(busy_3), .done(done_3),
    .err_count(ec_3), .ham_sum(hs_3), .bit_err(be_3), .abs_err_sum(as_3), .max_abs_err(mx_3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulses start, then counts cycles until each build raises done (bounded).
  task automatic do_sweep(input int m, output int lat0, output int lat1, output int lat3,
                          output int busy1);
    mode = m;
    lat0 = 0; lat1 = 0; lat3 = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("done_clr", done_1, 0);
    busy1 = busy_1 ? 1 : 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (busy_1) busy1++;
      if (done_0 && lat0 == 0) lat0 = n;
      if (done_1 && lat1 == 0) lat1 = n;
      if (done_3 && lat3 == 0) lat3 = n;
      if (lat0 != 0 && lat1 != 0 && lat3 != 0) break;
    end
    check("lat0", lat0, 65);
    check("lat1", lat1, 66);
    check("lat3", lat3, 68);
  endtask

  task automatic check_all(input int ec, input int hs, input int b0, input int b1,
                           input int b2, input int b3, input int as_e, input int mx);
    check("err_count", ec_1, ec);
    check("ham_sum", hs_1, hs);
    check("bit_err0", be_1[0 +: 7], b0);
    check("bit_err1", be_1[7 +: 7], b1);
    check("bit_err2", be_1[14 +: 7], b2);
    check("bit_err3", be_1[21 +: 7], b3);
    check("abs_sum", as_1, as_e);
    check("max_abs", mx_1, mx);
    check("l0_err", ec_0, ec);
    check("l0_ham", hs_0, hs);
    check("l0_abs", as_0, as_e);
    check("l0_max", mx_0, mx);
    check("l3_err", ec_3, ec);
    check("l3_ham", hs_3, hs);
    check("l3_abs", as_3, as_e);
    check("l3_max", mx_3, mx);
    check("l3_bits", be_3, be_1);
  endtask

  int l0, l1, l3, bc;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_1, 0);
    check("rst_done", done_1, 0);
    check("rst_vv", vv_1, 0);
    check("rst_vec", vec_1, 0);
    check("rst_err", ec_1, 0);
    check("rst_abs", as_1, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    do_sweep(0, l0, l1, l3, bc);
    check("busy_cycles", bc, 65);
    check_all(0, 0, 0, 0, 0, 0, 0, 0);

    do_sweep(1, l0, l1, l3, bc);
    check_all(64, 64, 64, 0, 0, 0, 64, 1);

    do_sweep(2, l0, l1, l3, bc);
    check_all(16, 16, 0, 0, 16, 0, 64, 4);

    do_sweep(3, l0, l1, l3, bc);
    check_all(64, 256, 64, 64, 64, 64, 960, 15);
    check("vec_hold", vec_1, 63);

    // Back-to-back restart from DONE must wipe the worst-case results.
    do_sweep(0, l0, l1, l3, bc);
    check_all(0, 0, 0, 0, 0, 0, 0, 0);

    // Mid-sweep: a stray start is ignored, then reset aborts the sweep.
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 40 && vec_1 != 6'd10; n++) @(posedge clk) #1;
    check("at_vec10", vec_1, 10);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("ign_start", vec_1, 11);
    for (int n = 0; n < 40 && vec_1 != 6'd30; n++) @(posedge clk) #1;
    check("at_vec30", vec_1, 30);
    check("pre_rst_err", ec_1, 29);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy", busy_1, 0);
    check("mid_rst_vv", vv_1, 0);
    check("mid_rst_vec", vec_1, 0);
    check("mid_rst_err", ec_1, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_err", ec_1, 0);
    check("idle_done", done_1, 0);

    do_sweep(0, l0, l1, l3, bc);
    check("busy_cycles2", bc, 65);
    check_all(0, 0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adder16_0_err_eval.md
Name: adder16_0_err_eval

Overview:
- Sequential evaluation stage around one BMF partition of adder16 (6 inputs, 4 outputs).
- Sweeps all 2^NI input vectors into the exact and approximate partition netlists, which are instantiated externally and driven in parallel.
- Consumes both output words and accumulates error metrics: mismatching-vector count, Hamming sum, per-bit flip counts, absolute-error sum and maximum.
- Ranks candidate factorization degrees k without offline simulation.

Parameters:
- NI, 6, partition input count; sweep length is 2^NI.
- NO, 4, partition output count; outputs are compared as NO-bit unsigned words, MSB = po(NO-1).
- LAT, 1, cycles from vec_out to the matching approx_in/exact_in; range 0..4, where 0 means combinational feedback.

Ports:
- clk  in  1  clock, all flops rising-edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a sweep
- vec_out  out  NI  input vector to both partitions (pi0 = bit 0)
- vec_valid  out  1  vec_out is a sweep vector this cycle
- exact_in  in  NO  exact partition outputs for the vector issued LAT cycles earlier
- approx_in  in  NO  approximate partition outputs, same alignment
- busy  out  1  sweep or drain in progress
- done  out  1  results final and stable
- err_count  out  NI+1  number of vectors with approx_in != exact_in
- ham_sum  out  NI+3  total differing output bits
- bit_err  out  NO*(NI+1)  per-output-bit flip counts, bit b at slice [b*(NI+1) +: NI+1]
- abs_err_sum  out  NI+NO  sum of |approx - exact|
- max_abs_err  out  NO  maximum |approx - exact|

Behaviour:
- Reset, applied in any state including mid-sweep:
  - State IDLE.
  - vec_out, vec_valid, busy, done all 0.
  - All accumulators and the valid delay line 0.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - start=1 -> SWEEP next cycle.
  - All accumulators clear on the same edge.
- SWEEP:
  - vec_valid=1 and busy=1.
  - vec_out starts at 0 and increments by 1 each cycle.
  - After vec_out = 2^NI-1 is presented, go to DRAIN if LAT>0, otherwise to DONE.
  - vec_out holds 2^NI-1 after the sweep and never wraps.
- DRAIN:
  - vec_valid=0, busy=1.
  - Lasts exactly LAT cycles, then DONE.
- DONE:
  - done=1, busy=0; accumulators hold.
  - start=1 -> clear accumulators and done, enter SWEEP next cycle (restart).
- start while busy is ignored.
- Alignment: vec_valid feeds a LAT-deep delay line. When the delayed valid is 1, exact_in/approx_in are sampled and the metrics update on that edge. Samples at any other time are ignored.
- Per-sample update:
  - diff = approx_in ^ exact_in.
  - err_count += (diff != 0).
  - ham_sum += popcount(diff).
  - bit_err[b] += diff[b] for each b.
  - ae = |approx_in - exact_in| as unsigned NO-bit magnitude.
  - abs_err_sum += ae.
  - max_abs_err = max(max_abs_err, ae).
- Widths are sized so no saturation or overflow is reachable over one sweep:
  - err_count max 2^NI.
  - ham_sum max NO*2^NI.
  - abs_err_sum max (2^NO-1)*2^NI.
- Timing (start sampled high at edge t):
  - Vectors are presented in cycles t+1 .. t+2^NI.
  - The last sample updates at edge t+2^NI+LAT.
  - done rises at edge t+2^NI+LAT+1.
  - Outputs are final whenever done=1.
- Outputs are registered except vec_out/vec_valid, which are also registered (state-derived flops).

Test Plan:
- Exact equals approx (both driven by a model of the exact adder partition), LAT=1 -> all metrics 0; done rises 2^NI+2 cycles after start; busy high for 65 cycles.
- approx = exact ^ 4'b0001 for every vector -> err_count=64, ham_sum=64, bit_err[0]=64, other bit_err=0, abs_err_sum=64, max_abs_err=1.
- approx = exact with bit 2 forced to 0; exact bit 2 is high on 16 vectors -> err_count=16, ham_sum=16, bit_err[2]=16, abs_err_sum=64, max_abs_err=4.
- Worst case: exact=0, approx=4'hF on all 64 vectors -> err_count=64, ham_sum=256, abs_err_sum=960, max_abs_err=15; no wrap.
- rst asserted at vector 30, then start again with an identical-output model -> all metrics 0, done only after a full 64-vector sweep; a start pulse at vector 10 is ignored.
- LAT=0 and LAT=3 builds with the delayed-output model -> identical metrics to LAT=1; done latency 2^NI+LAT+1; a back-to-back restart from DONE clears the old results.
